// File: rtl/timer_pkg.sv
// Shared widths and keypad encoder for the timer front end.
package timer_pkg;

    localparam int unsigned KEY_W   = 10;
    localparam int unsigned DIGIT_W = 4;

    // Highest set key index wins; all-zero input encodes to 0.
    function automatic logic [DIGIT_W-1:0] encode_key(input logic [KEY_W-1:0] key);
        logic [DIGIT_W-1:0] code;
        code = '0;
        for (int i = 0; i < KEY_W; i++) begin
            if (key[i]) code = DIGIT_W'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/entrada_time_keypad_loader_if.sv
// Keypad-in / digit-load-out bundle between the keypad source and the time-entry loader.
interface entrada_time_keypad_loader_if;
    import timer_pkg::*;

    logic [KEY_W-1:0]   keypad;
    logic               enablen;
    logic [DIGIT_W-1:0] D;
    logic               loadn;
    logic               pgt_1Hz;

    modport master (output keypad, enablen, input D, loadn, pgt_1Hz);
    modport slave  (input keypad, enablen, output D, loadn, pgt_1Hz);

endinterface

// File: rtl/timebase_div.sv
// Divides clk into a 50% duty square wave with a period of CLK_DIV cycles.
module timebase_div #(
    parameter int unsigned CLK_DIV = 100
) (
    input  logic clk,
    input  logic reset,
    output logic tick_sq
);

    localparam int unsigned HALF  = CLK_DIV / 2;
    localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            tick_sq <= 1'b0;
        end else if (count == CNT_W'(HALF - 1)) begin
            count   <= '0;
            tick_sq <= ~tick_sq;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/entrada_time_keypad_loader.sv
// Debounces the 10-key keypad, encodes it to BCD and strobes loadn once per new key;
// also hosts the 1 Hz timebase divider.
module entrada_time_keypad_loader
    import timer_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 100,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    entrada_time_keypad_loader_if.slave  bus
);

    localparam int unsigned CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [KEY_W-1:0]   kp_q;
    logic [KEY_W-1:0]   accepted;
    logic [CNT_W-1:0]   stable_cnt;
    logic               load_req;
    logic [DIGIT_W-1:0] digit;
    logic               strobe_n;
    logic               pgt_q;

    logic               same_c;
    logic               accept_c;
    int unsigned        run_len_c;

    // run_len_c counts this edge's sample plus the identical samples before it.
    always_comb begin
        same_c    = (bus.keypad == kp_q);
        run_len_c = same_c ? (32'(stable_cnt) + 32'd2) : 32'd1;
        accept_c  = (run_len_c >= DEBOUNCE) && (bus.keypad != accepted);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kp_q       <= '0;
            stable_cnt <= '0;
            accepted   <= '0;
            load_req   <= 1'b0;
            digit      <= '0;
            strobe_n   <= 1'b1;
        end else begin
            kp_q <= bus.keypad;

            if (!same_c) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_W'(DEBOUNCE - 1)) begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end

            if (accept_c) accepted <= bus.keypad;

            // Releases and keys accepted while disabled update tracking but never load.
            load_req <= accept_c && (bus.keypad != '0) && !bus.enablen;
            strobe_n <= ~load_req;
            if (load_req) digit <= encode_key(accepted);
        end
    end

    timebase_div #(.CLK_DIV(CLK_DIV)) u_timebase_div (
        .clk     (clk),
        .reset   (reset),
        .tick_sq (pgt_q)
    );

    assign bus.D       = digit;
    assign bus.loadn   = strobe_n;
    assign bus.pgt_1Hz = pgt_q;

endmodule

// File: tb/tb_entrada_time_keypad_loader.sv
// Directed bench for the keypad loader: strobe timing, priority, enable gating, divider.
module tb_entrada_time_keypad_loader;
    import timer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    entrada_time_keypad_loader_if bus ();

    entrada_time_keypad_loader #(.CLK_DIV(100), .DEBOUNCE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic exp_pgt;
        reset = 1'b1;
        bus.keypad = '0;
        bus.enablen = 1'b0;
        step();
        step();
        n_checks++;
        if (bus.D !== 4'd0) begin n_fail++; $display("FAIL reset_D got %0d expected 0", bus.D); end
        n_checks++;
        if (bus.loadn !== 1'b1) begin n_fail++; $display("FAIL reset_loadn got %b expected 1", bus.loadn); end
        n_checks++;
        if (bus.pgt_1Hz !== 1'b0) begin n_fail++; $display("FAIL reset_pgt got %b expected 0", bus.pgt_1Hz); end
        reset = 1'b0;
        for (int n = 1; n <= 201; n++) begin
            step();
            exp_pgt = ((n / 50) % 2) == 1;
            n_checks++;
            if (bus.pgt_1Hz !== exp_pgt) begin
                n_fail++; $display("FAIL idle_pgt edge %0d got %b expected %b", n, bus.pgt_1Hz, exp_pgt);
            end
            n_checks++;
            if (bus.loadn !== 1'b1 || bus.D !== 4'd0) begin
                n_fail++; $display("FAIL idle_out edge %0d got loadn=%b D=%0d expected loadn=1 D=0", n, bus.loadn, bus.D);
            end
        end
    endtask

    task automatic test_key9();
        logic       exp_ln;
        logic [3:0] exp_d;
        bus.keypad = 10'b1000000000;
        for (int n = 1; n <= 100; n++) begin
            step();
            exp_ln = (n != 5);
            exp_d  = (n >= 5) ? 4'd9 : 4'd0;
            n_checks++;
            if (bus.loadn !== exp_ln || bus.D !== exp_d) begin
                n_fail++; $display("FAIL key9 edge %0d got loadn=%b D=%0d expected loadn=%b D=%0d", n, bus.loadn, bus.D, exp_ln, exp_d);
            end
        end
    endtask

    task automatic test_direct_change();
        logic       exp_ln;
        logic [3:0] exp_d;
        bus.keypad = 10'b0100000000;
        for (int n = 1; n <= 40; n++) begin
            step();
            exp_ln = (n != 5);
            exp_d  = (n >= 5) ? 4'd8 : 4'd9;
            n_checks++;
            if (bus.loadn !== exp_ln || bus.D !== exp_d) begin
                n_fail++; $display("FAIL direct edge %0d got loadn=%b D=%0d expected loadn=%b D=%0d", n, bus.loadn, bus.D, exp_ln, exp_d);
            end
        end
    endtask

    task automatic test_disabled();
        bus.enablen = 1'b1;
        bus.keypad  = 10'b0000000100;
        for (int n = 1; n <= 100; n++) begin
            step();
            n_checks++;
            if (bus.loadn !== 1'b1 || bus.D !== 4'd8) begin
                n_fail++; $display("FAIL disabled edge %0d got loadn=%b D=%0d expected loadn=1 D=8", n, bus.loadn, bus.D);
            end
        end
        bus.enablen = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            step();
            n_checks++;
            if (bus.loadn !== 1'b1 || bus.D !== 4'd8) begin
                n_fail++; $display("FAIL reenable edge %0d got loadn=%b D=%0d expected loadn=1 D=8", n, bus.loadn, bus.D);
            end
        end
    endtask

    task automatic test_multihot();
        logic       exp_ln;
        logic [3:0] exp_d;
        bus.keypad = 10'b0000100010;
        for (int n = 1; n <= 30; n++) begin
            step();
            exp_ln = (n != 5);
            exp_d  = (n >= 5) ? 4'd5 : 4'd8;
            n_checks++;
            if (bus.loadn !== exp_ln || bus.D !== exp_d) begin
                n_fail++; $display("FAIL multihot edge %0d got loadn=%b D=%0d expected loadn=%b D=%0d", n, bus.loadn, bus.D, exp_ln, exp_d);
            end
        end
        // Glitch lasting one sample short of the debounce length.
        bus.keypad = 10'b0010000000;
        for (int n = 1; n <= 3; n++) step();
        bus.keypad = 10'b0000100010;
        for (int n = 1; n <= 20; n++) begin
            step();
            n_checks++;
            if (bus.loadn !== 1'b1 || bus.D !== 4'd5) begin
                n_fail++; $display("FAIL glitch edge %0d got loadn=%b D=%0d expected loadn=1 D=5", n, bus.loadn, bus.D);
            end
        end
        bus.keypad = '0;
        for (int n = 1; n <= 20; n++) begin
            step();
            n_checks++;
            if (bus.loadn !== 1'b1 || bus.D !== 4'd5) begin
                n_fail++; $display("FAIL release edge %0d got loadn=%b D=%0d expected loadn=1 D=5", n, bus.loadn, bus.D);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic       exp_ln;
        logic [3:0] exp_d;
        bus.keypad = 10'b0000001000;
        for (int n = 1; n <= 5; n++) begin
            step();
            exp_ln = (n != 5);
            exp_d  = (n >= 5) ? 4'd3 : 4'd5;
            n_checks++;
            if (bus.loadn !== exp_ln || bus.D !== exp_d) begin
                n_fail++; $display("FAIL key3 edge %0d got loadn=%b D=%0d expected loadn=%b D=%0d", n, bus.loadn, bus.D, exp_ln, exp_d);
            end
        end
        reset = 1'b1;
        step();
        n_checks++;
        if (bus.loadn !== 1'b1 || bus.D !== 4'd0 || bus.pgt_1Hz !== 1'b0) begin
            n_fail++; $display("FAIL midreset got loadn=%b D=%0d pgt=%b expected loadn=1 D=0 pgt=0", bus.loadn, bus.D, bus.pgt_1Hz);
        end
        reset = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            step();
            exp_ln = (n != 5);
            exp_d  = (n >= 5) ? 4'd3 : 4'd0;
            n_checks++;
            if (bus.loadn !== exp_ln || bus.D !== exp_d) begin
                n_fail++; $display("FAIL postreset edge %0d got loadn=%b D=%0d expected loadn=%b D=%0d", n, bus.loadn, bus.D, exp_ln, exp_d);
            end
            n_checks++;
            if (bus.pgt_1Hz !== (n >= 50)) begin
                n_fail++; $display("FAIL postreset_pgt edge %0d got %b expected %b", n, bus.pgt_1Hz, (n >= 50));
            end
        end
    endtask

    initial begin
        test_reset();
        test_key9();
        test_direct_change();
        test_disabled();
        test_multihot();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/entrada_time_keypad_loader.md
Name: entrada_time_keypad_loader

Overview:
- Time-entry front end for the timer datapath.
- Takes a 10-key one-hot keypad (digits 0-9), debounces it and priority-encodes it to BCD on D.
- Issues a one-cycle active-low load strobe (loadn) so the downstream digit/shift register captures D.
- Also divides the system clock into the 1 Hz timebase square wave pgt_1Hz used by the countdown logic.

Parameters:
- CLK_DIV, 100: clk cycles per pgt_1Hz period; even, >=2; 100 for simulation, board value set at instantiation.
- DEBOUNCE, 4: consecutive identical keypad samples required before a keypad value is accepted; >=1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- keypad  input  10  key bits, bit i = digit i pressed (active high); may be multi-hot or all zero.
- enablen  input  1  active-low entry enable; 1 blocks loads.
- D  output  4  BCD digit of last loaded key (0-9), registered.
- loadn  output  1  active-low load strobe, registered, one cycle per accepted key.
- pgt_1Hz  output  1  1 Hz timebase, 50% duty square wave, registered.

Behaviour:
- Reset (reset=1 at a rising edge) drives and holds all of the following:
  - D=0, loadn=1, pgt_1Hz=0.
  - Divider count=0, debounce count=0.
  - Sample register=0, accepted vector=0.
- Priority encode: D code = index of the highest set bit of the accepted vector (bit9 wins over bit8, etc.).
- Debounce:
  - keypad is registered every edge into kp_q.
  - Stability counter clears when the incoming keypad differs from kp_q, else increments (saturating at DEBOUNCE-1).
  - A vector is accepted when it has been sampled identical on DEBOUNCE consecutive edges and differs from the current accepted vector; the accepted vector updates on that edge.
- Load:
  - Condition: a vector is accepted, it is nonzero, and enablen=0 on that edge.
  - On the next edge, D <= encoded value and loadn <= 0.
  - loadn returns to 1 on the following edge: exactly one cycle low.
  - Latency from keypad change to loadn low is DEBOUNCE+1 rising edges.
- Direct key-to-key change (e.g. 9 then 8 with no release) is a new accepted vector and produces a new load.
- Release (all zeros) is accepted silently: no load, D holds.
- enablen=1: accepted-vector tracking continues, but no load occurs and D/loadn hold.
  - A key accepted while disabled does not load when enablen later falls; a fresh change is needed.
- Key held continuously produces exactly one load, with no auto-repeat.
- Divider:
  - Count 0..CLK_DIV/2-1; on reaching CLK_DIV/2-1 the count wraps to 0 and pgt_1Hz toggles.
  - Period is CLK_DIV cycles; the first rising edge of pgt_1Hz occurs at edge CLK_DIV/2 after reset release.
  - The divider is independent of keypad and enablen.
- Reset asserted mid-strobe forces loadn=1 on that edge; a pending load is discarded.
- Reset asserted mid-debounce restarts the stability count.

Decomposition:
- Shared package timer_pkg:
  - KEY_W=10, DIGIT_W=4.
  - Encoder function (one-hot/multi-hot to BCD, highest-index priority).
- One sub-module is natural: timebase_div (clk, reset, parameter CLK_DIV, output tick_sq), producing pgt_1Hz.
- Debounce and load strobe stay in the top block.

Test Plan:
- Reset then idle, keypad=0, enablen=0 for 201 edges -> D=0, loadn stays 1. pgt_1Hz toggles every 50 edges (rises at edge 50, falls at 100, rises at 150).
- keypad=10'b1000000000, enablen=0, held 100 cycles -> loadn low for exactly one cycle at edge DEBOUNCE+1=5; D=9 from that edge on; no further strobes.
- Switch directly to keypad=10'b0100000000 -> one more loadn pulse 5 edges later, D=8.
- keypad=10'b0000000100 with enablen=1 held 100 cycles -> no loadn pulse, D stays 8. Then enablen=0 with key still held -> still no pulse.
- Multi-hot keypad=10'b0000100010, enablen=0 -> single pulse, D=5. Glitch shorter than DEBOUNCE edges -> ignored, no pulse.
- Assert reset for 1 cycle during a loadn=0 cycle and mid divider count -> next edge loadn=1, D=0, pgt_1Hz=0; divider restarts (next rise 50 edges later).
